// File: rtl/hazard_if.sv
// Pipeline hazard bus: stage register/control info into the hazard unit,
// forwarding selects, stall/flush controls and memory-wait status out of it.
interface hazard_if #(
  parameter int CNT_WIDTH = 16
);
  logic [4:0]           rs1_d;
  logic [4:0]           rs2_d;
  logic [4:0]           rs1_e;
  logic [4:0]           rs2_e;
  logic [4:0]           rd_e;
  logic [1:0]           resultSrc_e;
  logic                 pcSrc_e;
  logic                 regWrite_m;
  logic [4:0]           rd_m;
  logic                 regWrite_w;
  logic [4:0]           rd_w;
  logic                 memReq_m;
  logic                 memReady;
  logic [1:0]           forwardA_e;
  logic [1:0]           forwardB_e;
  logic                 stall_f;
  logic                 stall_d;
  logic                 stall_e;
  logic                 stall_m;
  logic                 flush_d;
  logic                 flush_e;
  logic                 flush_w;
  logic                 memBusy;
  logic                 memTimeout;
  logic [CNT_WIDTH-1:0] stallCycles;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, resultSrc_e, pcSrc_e,
           regWrite_m, rd_m, regWrite_w, rd_w, memReq_m, memReady,
    input  forwardA_e, forwardB_e, stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_w, memBusy, memTimeout, stallCycles
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, resultSrc_e, pcSrc_e,
           regWrite_m, rd_m, regWrite_w, rd_w, memReq_m, memReady,
    output forwardA_e, forwardB_e, stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_w, memBusy, memTimeout, stallCycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use and branch
// handling, memory-wait FSM with timeout, and a saturating stall counter.
module hazard_ctrl #(
  parameter int TIMEOUT   = 15,
  parameter int CNT_WIDTH = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  hazard_if.slave bus
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                 mem_busy_q, mem_busy_d;
  logic                 mem_timeout_q, mem_timeout_d;
  logic                 load_use;
  logic                 mem_stall;
  logic                 in_error;
  logic [6:0]           ctl;
  logic [4:0]           rs_e [2];
  logic [1:0]           fwd  [2];

  assign rs_e[0] = bus.rs1_e;
  assign rs_e[1] = bus.rs2_e;

  // M has priority over W; x0 is never forwarded.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd[gi] = (bus.regWrite_m && (bus.rd_m != 5'd0) && (bus.rd_m == rs_e[gi])) ? 2'b10 :
                       (bus.regWrite_w && (bus.rd_w != 5'd0) && (bus.rd_w == rs_e[gi])) ? 2'b01 :
                                                                                           2'b00;
    end
  endgenerate

  assign bus.forwardA_e = fwd[0];
  assign bus.forwardB_e = fwd[1];

  assign in_error  = (state_q == ERROR);
  assign mem_stall = !in_error && bus.memReq_m && !bus.memReady;
  assign load_use  = (bus.resultSrc_e == 2'b01) && (bus.rd_e != 5'd0) &&
                     ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d));

  // ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
  always_comb begin
    ctl = 7'b000_0000;
    if (!rst_n) begin
      ctl = 7'b000_0000;
    end else if (in_error || mem_stall) begin
      ctl = 7'b111_1001;
    end else if (bus.pcSrc_e) begin
      ctl = 7'b000_0110;
    end else if (load_use) begin
      ctl = 7'b110_0010;
    end
  end

  assign {bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m,
          bus.flush_d, bus.flush_e, bus.flush_w} = ctl;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (bus.memReady) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          // This cycle completes the TIMEOUT-th wait cycle.
          if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
            state_d = ERROR;
          end
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (ctl[6] && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    mem_busy_d    = (state_d == MEM_WAIT);
    mem_timeout_d = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      mem_busy_q    <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      mem_busy_q    <= mem_busy_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign bus.memBusy     = mem_busy_q;
  assign bus.memTimeout  = mem_timeout_q;
  assign bus.stallCycles = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed memory-wait,
// timeout, reset and saturation sequences, then randomized traffic.
module tb_hazard_ctrl;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_if #(.CNT_WIDTH(16)) bus ();
  hazard_if #(.CNT_WIDTH(4))  bus4 ();

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  assign bus4.rs1_d       = bus.rs1_d;
  assign bus4.rs2_d       = bus.rs2_d;
  assign bus4.rs1_e       = bus.rs1_e;
  assign bus4.rs2_e       = bus.rs2_e;
  assign bus4.rd_e        = bus.rd_e;
  assign bus4.resultSrc_e = bus.resultSrc_e;
  assign bus4.pcSrc_e     = bus.pcSrc_e;
  assign bus4.regWrite_m  = bus.regWrite_m;
  assign bus4.rd_m        = bus.rd_m;
  assign bus4.regWrite_w  = bus.regWrite_w;
  assign bus4.rd_w        = bus.rd_w;
  assign bus4.memReq_m    = bus.memReq_m;
  assign bus4.memReady    = bus.memReady;

  typedef struct packed {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic [1:0] res;
    logic       pc, rwm;
    logic [4:0] rdm;
    logic       rww;
    logic [4:0] rdw;
    logic       req, rdy;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [1:0] fa, fb;
    logic [6:0] ctl;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pipeline mode and counters as plain integers.
  bit m_err, m_wait;
  int m_wcnt, m_cnt, m_cnt4;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_err = 0; m_wait = 0; m_wcnt = 0; m_cnt = 0; m_cnt4 = 0;
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (bus.regWrite_m && bus.rd_m != 0 && bus.rd_m == rs) return 2'b10;
    if (bus.regWrite_w && bus.rd_w != 0 && bus.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [6:0] exp_ctl();
    bit ms, lu;
    if (!rst_n) return 7'b0;
    ms = !m_err && bus.memReq_m && !bus.memReady;
    lu = (bus.resultSrc_e == 2'b01) && (bus.rd_e != 0) &&
         (bus.rd_e == bus.rs1_d || bus.rd_e == bus.rs2_d);
    if (m_err || ms) return 7'b1111001;
    if (bus.pcSrc_e) return 7'b0000110;
    if (lu)          return 7'b1100010;
    return 7'b0;
  endfunction

  task automatic model_edge();
    logic [6:0] c;
    bit ms;
    if (!rst_n) return;
    c  = exp_ctl();
    ms = !m_err && bus.memReq_m && !bus.memReady;
    if (c[6]) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (m_err) begin
      m_err = 1;
    end else if (!m_wait) begin
      if (ms) begin m_wait = 1; m_wcnt = 0; end
    end else if (bus.memReady) begin
      m_wait = 0;
    end else begin
      m_wcnt++;
      if (m_wcnt == TIMEOUT) begin m_err = 1; m_wait = 0; end
    end
  endtask

  function automatic logic [6:0] act_ctl();
    return {bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m,
            bus.flush_d, bus.flush_e, bus.flush_w};
  endfunction

  task automatic check_model();
    chk("fwdA", 32'(bus.forwardA_e), 32'(exp_fwd(bus.rs1_e)));
    chk("fwdB", 32'(bus.forwardB_e), 32'(exp_fwd(bus.rs2_e)));
    chk("ctl", 32'(act_ctl()), 32'(exp_ctl()));
    chk("memBusy", 32'(bus.memBusy), 32'(m_wait));
    chk("memTimeout", 32'(bus.memTimeout), 32'(m_err));
    chk("stallCycles", 32'(bus.stallCycles), 32'(m_cnt));
    chk("stallCycles4", 32'(bus4.stallCycles), 32'(m_cnt4));
  endtask

  task automatic drive(input in_t x);
    bus.rs1_d = x.rs1_d; bus.rs2_d = x.rs2_d; bus.rs1_e = x.rs1_e;
    bus.rs2_e = x.rs2_e; bus.rd_e = x.rd_e; bus.resultSrc_e = x.res;
    bus.pcSrc_e = x.pc; bus.regWrite_m = x.rwm; bus.rd_m = x.rdm;
    bus.regWrite_w = x.rww; bus.rd_w = x.rdw;
    bus.memReq_m = x.req; bus.memReady = x.rdy;
  endtask

  // Apply inputs on the falling edge and check once they have settled.
  task automatic settle(input in_t x, input bit rst_val);
    @(negedge clk);
    rst_n = rst_val;
    drive(x);
    if (!rst_n) model_reset();
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
  endtask

  function automatic in_t fw(bit rwm, logic [4:0] rdm, bit rww, logic [4:0] rdw,
                             logic [4:0] r1, logic [4:0] r2);
    in_t x = '0;
    x.rwm = rwm; x.rdm = rdm; x.rww = rww; x.rdw = rdw; x.rs1_e = r1; x.rs2_e = r2;
    x.rdy = 1;
    return x;
  endfunction

  function automatic in_t lu(logic [1:0] res, logic [4:0] rde, logic [4:0] r1d,
                             logic [4:0] r2d, bit pc);
    in_t x = '0;
    x.res = res; x.rd_e = rde; x.rs1_d = r1d; x.rs2_d = r2d; x.pc = pc; x.rdy = 1;
    return x;
  endfunction

  function automatic vec_t mk(string nm, in_t x, logic [1:0] fa, logic [1:0] fb, logic [6:0] c);
    vec_t v;
    v.name = nm; v.in = x; v.fa = fa; v.fb = fb; v.ctl = c;
    return v;
  endfunction

  vec_t vecs[11];

  initial begin
    in_t idle, x;
    int  c0;

    idle = '0;
    idle.rdy = 1;
    vecs[0]  = mk("fwd_m_over_w", fw(1, 5, 1, 5, 5, 0), 2'b10, 2'b00, 7'b0);
    vecs[1]  = mk("fwd_rdm_zero", fw(1, 0, 1, 5, 5, 0), 2'b01, 2'b00, 7'b0);
    vecs[2]  = mk("fwd_b_from_m", fw(1, 5, 0, 5, 3, 5), 2'b00, 2'b10, 7'b0);
    vecs[3]  = mk("fwd_both_w",   fw(0, 5, 1, 9, 9, 9), 2'b01, 2'b01, 7'b0);
    vecs[4]  = mk("fwd_x0_never", fw(1, 0, 1, 0, 0, 0), 2'b00, 2'b00, 7'b0);
    vecs[5]  = mk("lu_rs2",       lu(2'b01, 7, 0, 7, 0), 2'b00, 2'b00, 7'b1100010);
    vecs[6]  = mk("lu_rs1",       lu(2'b01, 7, 7, 0, 0), 2'b00, 2'b00, 7'b1100010);
    vecs[7]  = mk("lu_rd0",       lu(2'b01, 0, 0, 0, 0), 2'b00, 2'b00, 7'b0);
    vecs[8]  = mk("no_load",      lu(2'b00, 7, 0, 7, 0), 2'b00, 2'b00, 7'b0);
    vecs[9]  = mk("branch_lu",    lu(2'b01, 7, 0, 7, 1), 2'b00, 2'b00, 7'b0000110);
    vecs[10] = mk("branch_only",  lu(2'b00, 0, 0, 0, 1), 2'b00, 2'b00, 7'b0000110);

    // Reset state: outputs quiet, counters zero while rst_n is low.
    model_reset();
    settle(fw(1, 4, 0, 0, 4, 0), 0);
    chk("rst_fwdA", 32'(bus.forwardA_e), 32'h2);
    tick();
    settle(idle, 0);
    tick();

    foreach (vecs[i]) begin
      settle(vecs[i].in, 1);
      chk({vecs[i].name, "_fa"}, 32'(bus.forwardA_e), 32'(vecs[i].fa));
      chk({vecs[i].name, "_fb"}, 32'(bus.forwardB_e), 32'(vecs[i].fb));
      chk({vecs[i].name, "_ctl"}, 32'(act_ctl()), 32'(vecs[i].ctl));
      tick();
      $display("vec %0d %s ctl=%b", i, vecs[i].name, act_ctl());
    end

    // Memory wait: three stalled cycles, released in the memReady cycle.
    c0 = m_cnt;
    x = idle; x.req = 1; x.rdy = 0;
    for (int k = 1; k <= 3; k++) begin
      settle(x, 1);
      chk("mw_ctl", 32'(act_ctl()), 32'h79);
      chk("mw_busy", 32'(bus.memBusy), 32'(k >= 2));
      tick();
    end
    x.rdy = 1;
    settle(x, 1);
    chk("mw_release_ctl", 32'(act_ctl()), 32'h0);
    chk("mw_release_busy", 32'(bus.memBusy), 32'h1);
    chk("mw_count", 32'(bus.stallCycles), 32'(c0 + 3));
    tick();
    settle(idle, 1);
    chk("mw_busy_off", 32'(bus.memBusy), 32'h0);
    tick();
    $display("memwait sequence done, stallCycles=%0d", bus.stallCycles);

    // Timeout: 15 MEM_WAIT cycles, then sticky ERROR until reset.
    settle(idle, 0);
    tick();
    x = idle; x.req = 1; x.rdy = 0;
    for (int k = 1; k <= 16; k++) begin
      settle(x, 1);
      chk("to_busy", 32'(bus.memBusy), 32'(k >= 2));
      chk("to_tmo", 32'(bus.memTimeout), 32'h0);
      tick();
    end
    settle(x, 1);
    chk("to_tmo_set", 32'(bus.memTimeout), 32'h1);
    tick();
    x.rdy = 1;
    for (int k = 0; k < 3; k++) begin
      settle(x, 1);
      chk("to_sticky", 32'(bus.memTimeout), 32'h1);
      chk("to_stall", 32'(act_ctl()), 32'h79);
      tick();
    end
    settle(idle, 1);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("async_tmo", 32'(bus.memTimeout), 32'h0);
    chk("async_cnt", 32'(bus.stallCycles), 32'h0);
    chk("async_ctl", 32'(act_ctl()), 32'h0);
    tick();
    $display("timeout sequence done");

    // Saturation of the 4-bit counter under 20 cycles of load-use.
    settle(idle, 1);
    tick();
    for (int k = 1; k <= 20; k++) begin
      settle(lu(2'b01, 7, 0, 7, 0), 1);
      tick();
    end
    settle(idle, 1);
    chk("sat4", 32'(bus4.stallCycles), 32'd15);
    chk("sat16", 32'(bus.stallCycles), 32'd20);
    tick();
    settle(idle, 1);
    chk("sat4_hold", 32'(bus4.stallCycles), 32'd15);
    tick();
    $display("saturation sequence done");

    // Randomized traffic against the model, with timeout bursts and resets.
    for (int i = 0; i < 3000; i++) begin
      bit r;
      x.rs1_d = 5'($urandom_range(0, 7)); x.rs2_d = 5'($urandom_range(0, 7));
      x.rs1_e = 5'($urandom_range(0, 7)); x.rs2_e = 5'($urandom_range(0, 7));
      x.rd_e  = 5'($urandom_range(0, 7)); x.res   = 2'($urandom_range(0, 3));
      x.pc    = ($urandom_range(0, 7) == 0);
      x.rwm   = 1'($urandom); x.rdm = 5'($urandom_range(0, 7));
      x.rww   = 1'($urandom); x.rdw = 5'($urandom_range(0, 7));
      if ((i % 500) >= 400 && (i % 500) < 430) begin
        x.req = 1; x.rdy = 0;
      end else begin
        x.req = 1'($urandom); x.rdy = ($urandom_range(0, 3) != 0);
      end
      r = ((i % 250) != 249);
      settle(x, r);
      tick();
    end
    $display("random phase done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, giving the maximum consecutive memory-wait cycles before the error state.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of the stall performance counter.
REQ-003 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- rs1_d, rs2_d  in  5 each  decode-stage source registers.
- rs1_e, rs2_e, rd_e  in  5 each  execute-stage source and destination registers.
- resultSrc_e  in  2  execute-stage result select; 2'b01 = load.
- pcSrc_e  in  1  branch/jump taken in execute.
- regWrite_m, rd_m  in  1, 5  memory-stage write enable and destination.
- regWrite_w, rd_w  in  1, 5  writeback-stage write enable and destination.
- memReq_m  in  1  load or store active in the memory stage.
- memReady  in  1  data memory completes the access this cycle.
- forwardA_e, forwardB_e  out  2 each  operand select: 00 = register file, 01 = W, 10 = M.
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold the corresponding pipeline register.
- flush_d, flush_e, flush_w  out  1 each  load a bubble into decode, execute or the M/W register.
- memBusy  out  1  FSM in MEM_WAIT.
- memTimeout  out  1  FSM in ERROR (sticky).
- stallCycles  out  CNT_WIDTH  saturating count of stalled cycles.

Function
REQ-004 Forwarding SHALL be combinational, and M SHALL have priority over W.
- forwardA_e = 10 when regWrite_m, rd_m != 0 and rd_m == rs1_e.
- Otherwise forwardA_e = 01 when regWrite_w, rd_w != 0 and rd_w == rs1_e.
- Otherwise forwardA_e = 00.
- forwardB_e follows the same rules using rs2_e.
REQ-005 loadUse SHALL be asserted when resultSrc_e == 01, rd_e != 0, and rd_e equals rs1_d or rs2_d.
REQ-006 memStall SHALL be memReq_m AND NOT memReady, evaluated combinationally in RUN and MEM_WAIT.
REQ-007 The FSM SHALL have three states: RUN, MEM_WAIT and ERROR.
REQ-008 FSM transitions SHALL be:
- RUN to MEM_WAIT when memStall.
- MEM_WAIT to RUN when memReady.
- MEM_WAIT to ERROR when the wait counter reaches TIMEOUT with memReady low.
- ERROR is left only by reset.
REQ-009 The wait counter SHALL clear on entry to MEM_WAIT, increment once per MEM_WAIT cycle, and clear on return to RUN.
REQ-010 Output priority SHALL be ERROR, then memStall, then pcSrc_e, then loadUse:
- ERROR: all stall_* = 1, flush_w = 1, flush_d = flush_e = 0.
- memStall: all stall_* = 1, flush_w = 1, flush_d = flush_e = 0; a pending branch or load-use is deferred, not lost, because the inputs are held.
- pcSrc_e: flush_d = flush_e = 1 and all stalls 0; this applies even when loadUse is also true.
- loadUse: stall_f = stall_d = 1 and flush_e = 1; other outputs 0.
- Otherwise all stall and flush outputs are 0.
REQ-011 The cycle memReady rises in MEM_WAIT SHALL be unstalled, with memStall = 0 that same cycle; the pipeline advances on that edge.
REQ-012 stallCycles SHALL increment by 1 on each edge where stall_f = 1 (load-use, memStall or ERROR).
REQ-013 stallCycles SHALL saturate at all-ones and not wrap.
REQ-014 memBusy and memTimeout SHALL be decoded from the registered state only, with no combinational path from inputs.

Reset
REQ-015 Asserting rst_n low SHALL immediately force state = RUN, wait counter = 0, stallCycles = 0, memBusy = 0 and memTimeout = 0, regardless of the clock.
REQ-016 While rst_n is low, all stall and flush outputs SHALL be 0 and forwarding outputs SHALL follow REQ-004.
REQ-017 Reset asserted in MEM_WAIT or ERROR SHALL return the block to RUN, with the first post-reset edge evaluated as RUN.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Forwarding: regWrite_m = 1, rd_m = 5; regWrite_w = 1, rd_w = 5; rs1_e = 5 -> forwardA_e = 10. Repeat with rd_m = 0 -> forwardA_e = 01.
- Load-use: resultSrc_e = 01, rd_e = 7, rs2_d = 7 -> stall_f = stall_d = flush_e = 1 for one cycle; stallCycles increments by 1.
- Branch plus load-use: pcSrc_e = 1 with the load-use condition of the previous scenario -> flush_d = flush_e = 1, stall_f = 0.
- Memory wait: memReq_m = 1, memReady low for 3 cycles then high -> stall_* = 1 and flush_w = 1 for 3 cycles; memBusy high for 3 cycles; stalls drop in the memReady cycle; stallCycles increases by 3.
- Timeout: memReady held low with TIMEOUT = 15 -> memTimeout = 1 after the 15th MEM_WAIT cycle; stalls stay high; memReady = 1 has no effect; rst_n low clears memTimeout without a clock edge.
- Saturation: with CNT_WIDTH = 4, hold loadUse for 20 cycles -> stallCycles = 15 and remains 15.
